// File: rtl/hack_pkg.sv
// Shared definitions for the multi-cycle Hack CPU: FSM states, instruction
// field positions, jump codes and reset constants.
package hack_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_MEM_RD = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM_WR = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned IS_C    = 15;
  localparam int unsigned ABIT    = 12;
  localparam int unsigned CMP_HI  = 11;
  localparam int unsigned CMP_LO  = 6;
  localparam int unsigned DEST_A  = 5;
  localparam int unsigned DEST_D  = 4;
  localparam int unsigned DEST_M  = 3;
  localparam int unsigned JMP_HI  = 2;
  localparam int unsigned JMP_LO  = 0;

  localparam logic [2:0] J_NULL = 3'b000;
  localparam logic [2:0] J_GT   = 3'b001;
  localparam logic [2:0] J_EQ   = 3'b010;
  localparam logic [2:0] J_GE   = 3'b011;
  localparam logic [2:0] J_LT   = 3'b100;
  localparam logic [2:0] J_NE   = 3'b101;
  localparam logic [2:0] J_LE   = 3'b110;
  localparam logic [2:0] J_MP   = 3'b111;

  localparam state_e              RST_STATE = S_FETCH;
  localparam logic [INSTR_W-1:0]  RST_INSTR = 16'h0000;

  // j[2]: jump if negative, j[1]: if zero, j[0]: if positive
  function automatic logic jump_taken(input logic [2:0] j, input logic ng, input logic zr);
    return (j[2] & ng) | (j[1] & zr) | (j[0] & ~ng & ~zr);
  endfunction

endpackage

// File: rtl/hack_cpu_mc_if.sv
// Instruction-fetch and data-memory req/ack buses of the multi-cycle Hack CPU.
interface hack_cpu_mc_if #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned ADDR_WIDTH = 15
);
  logic                  imem_req;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic                  imem_ack;
  logic [15:0]           imem_rdata;
  logic                  dmem_req;
  logic                  dmem_we;
  logic [ADDR_WIDTH-1:0] dmem_addr;
  logic [WIDTH-1:0]      dmem_wdata;
  logic                  dmem_ack;
  logic [WIDTH-1:0]      dmem_rdata;

  modport master (
    output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  imem_ack, imem_rdata, dmem_ack, dmem_rdata
  );

  modport slave (
    input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output imem_ack, imem_rdata, dmem_ack, dmem_rdata
  );
endinterface

// File: rtl/hack_alu_n.sv
// Combinational WIDTH-bit Hack ALU (zx, nx, zy, ny, f, no) with zr/ng flags.
module hack_alu_n #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  input  logic             zx_i,
  input  logic             nx_i,
  input  logic             zy_i,
  input  logic             ny_i,
  input  logic             f_i,
  input  logic             no_i,
  output logic [WIDTH-1:0] out_o,
  output logic             zr_o,
  output logic             ng_o
);

  logic [WIDTH-1:0] xz, xn, yz, yn, fo;

  always_comb begin
    xz    = zx_i ? '0 : x_i;
    xn    = nx_i ? ~xz : xz;
    yz    = zy_i ? '0 : y_i;
    yn    = ny_i ? ~yz : yz;
    fo    = f_i ? (xn + yn) : (xn & yn);
    out_o = no_i ? ~fo : fo;
    zr_o  = (out_o == '0);
    ng_o  = out_o[WIDTH-1];
  end

endmodule

// File: rtl/hack_cpu_mc.sv
// Multi-cycle parametrised Hack CPU with req/ack instruction and data buses,
// self-loop halt detection and a per-instruction retire pulse.
module hack_cpu_mc
  import hack_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned ADDR_WIDTH = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  hack_cpu_mc_if.master         bus,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [WIDTH-1:0]      a_reg,
  output logic [WIDTH-1:0]      d_reg,
  output logic                  retire,
  output logic                  halted
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0]      a_q, a_d, d_q, d_d, mdr_q, mdr_d, res_q, res_d;
  logic [INSTR_W-1:0]    ir_q, ir_d;
  logic                  imem_req_q, imem_req_d;
  logic                  dmem_req_q, dmem_req_d;
  logic                  dmem_we_q, dmem_we_d;
  logic [ADDR_WIDTH-1:0] dmem_addr_q, dmem_addr_d;
  logic [WIDTH-1:0]      dmem_wdata_q, dmem_wdata_d;
  logic                  halted_q, halted_d;

  logic [WIDTH-1:0] alu_y, alu_out, res_c;
  logic             alu_zr, alu_ng, res_zr, res_ng;
  logic             imem_fire, dmem_fire, commit, taken, retire_c;

  assign alu_y = ir_q[ABIT] ? mdr_q : a_q;

  hack_alu_n #(.WIDTH(WIDTH)) u_alu (
    .x_i  (d_q),
    .y_i  (alu_y),
    .zx_i (ir_q[CMP_HI]),
    .nx_i (ir_q[CMP_HI-1]),
    .zy_i (ir_q[CMP_HI-2]),
    .ny_i (ir_q[CMP_HI-3]),
    .f_i  (ir_q[CMP_HI-4]),
    .no_i (ir_q[CMP_LO]),
    .out_o(alu_out),
    .zr_o (alu_zr),
    .ng_o (alu_ng)
  );

  // Commit value is the live ALU result in EXEC, the latched RES after a write
  always_comb begin
    res_c  = (state_q == S_EXEC) ? alu_out : res_q;
    res_zr = (state_q == S_EXEC) ? alu_zr : (res_q == '0);
    res_ng = (state_q == S_EXEC) ? alu_ng : res_q[WIDTH-1];
    taken  = jump_taken(ir_q[JMP_HI:JMP_LO], res_ng, res_zr);
  end

  assign imem_fire = imem_req_q & bus.imem_ack;
  assign dmem_fire = dmem_req_q & bus.dmem_ack;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    a_d          = a_q;
    d_d          = d_q;
    ir_d         = ir_q;
    mdr_d        = mdr_q;
    res_d        = res_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_wdata_d = dmem_wdata_q;
    commit       = 1'b0;
    retire_c     = 1'b0;

    case (state_q)
      S_FETCH: begin
        if (imem_fire) begin
          ir_d    = bus.imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!ir_q[IS_C]) begin
          a_d      = WIDTH'(ir_q[IS_C-1:0]);
          pc_d     = pc_q + ADDR_WIDTH'(1);
          retire_c = 1'b1;
          state_d  = S_FETCH;
        end else if (ir_q[ABIT]) begin
          state_d = S_MEM_RD;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_MEM_RD: begin
        if (dmem_fire) begin
          mdr_d   = bus.dmem_rdata;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        res_d = alu_out;
        if (ir_q[DEST_M]) begin
          dmem_wdata_d = alu_out;
          state_d      = S_MEM_WR;
        end else begin
          commit = 1'b1;
        end
      end
      S_MEM_WR: begin
        if (dmem_fire) commit = 1'b1;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase

    // A, D and pc only change here, so both memory phases see A_old
    if (commit) begin
      if (ir_q[DEST_A]) a_d = res_c;
      if (ir_q[DEST_D]) d_d = res_c;
      pc_d     = taken ? a_q[ADDR_WIDTH-1:0] : pc_q + ADDR_WIDTH'(1);
      retire_c = 1'b1;
      state_d  = (taken && (a_q == WIDTH'(pc_q))) ? S_HALT : S_FETCH;
    end

    imem_req_d = (state_d == S_FETCH);
    dmem_req_d = (state_d == S_MEM_RD) || (state_d == S_MEM_WR);
    dmem_we_d  = (state_d == S_MEM_WR);
    halted_d   = (state_d == S_HALT);
    if (dmem_req_d) dmem_addr_d = a_q[ADDR_WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RST_STATE;
      pc_q         <= '0;
      a_q          <= '0;
      d_q          <= '0;
      ir_q         <= RST_INSTR;
      mdr_q        <= '0;
      res_q        <= '0;
      imem_req_q   <= 1'b0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_wdata_q <= '0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      a_q          <= a_d;
      d_q          <= d_d;
      ir_q         <= ir_d;
      mdr_q        <= mdr_d;
      res_q        <= res_d;
      imem_req_q   <= imem_req_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_wdata_q <= dmem_wdata_d;
      halted_q     <= halted_d;
    end
  end

  assign bus.imem_req   = imem_req_q;
  assign bus.imem_addr  = pc_q;
  assign bus.dmem_req   = dmem_req_q;
  assign bus.dmem_we    = dmem_we_q;
  assign bus.dmem_addr  = dmem_addr_q;
  assign bus.dmem_wdata = dmem_wdata_q;
  assign pc             = pc_q;
  assign a_reg          = a_q;
  assign d_reg          = d_q;
  assign retire         = retire_c & ~reset;
  assign halted         = halted_q;

endmodule

// File: tb/tb_hack_cpu_mc.sv
// Scoreboard bench for hack_cpu_mc: directed programs push expected retires and
// memory accesses; monitors compare them as the CPU presents them.
module tb_hack_cpu_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, rst32;

  hack_cpu_mc_if #(.WIDTH(16), .ADDR_WIDTH(15)) bus16 ();
  hack_cpu_mc_if #(.WIDTH(32), .ADDR_WIDTH(15)) bus32 ();

  logic [14:0] pc16, pc32;
  logic [15:0] a16, d16;
  logic [31:0] a32, d32;
  logic        ret16, halt16, ret32, halt32;

  hack_cpu_mc #(.WIDTH(16), .ADDR_WIDTH(15)) dut (
    .clk(clk), .reset(reset), .bus(bus16), .pc(pc16), .a_reg(a16), .d_reg(d16),
    .retire(ret16), .halted(halt16)
  );

  hack_cpu_mc #(.WIDTH(32), .ADDR_WIDTH(15)) dut32 (
    .clk(clk), .reset(rst32), .bus(bus32), .pc(pc32), .a_reg(a32), .d_reg(d32),
    .retire(ret32), .halted(halt32)
  );

  // memory models with programmable wait states
  logic [15:0] rom [0:63];
  logic [15:0] ram [0:63];
  logic [15:0] prog32 [0:63];
  int   iwait, dwait;
  logic dack_en, force_dack;
  int   icnt = 0;
  int   dcnt = 0;

  assign bus16.imem_ack   = bus16.imem_req && (icnt == iwait);
  assign bus16.imem_rdata = rom[bus16.imem_addr[5:0]];
  assign bus16.dmem_ack   = (bus16.dmem_req && dack_en && (dcnt == dwait)) || force_dack;
  assign bus16.dmem_rdata = ram[bus16.dmem_addr[5:0]];

  always @(posedge clk) begin
    icnt <= (bus16.imem_req && !bus16.imem_ack) ? icnt + 1 : 0;
    dcnt <= (bus16.dmem_req && !bus16.dmem_ack) ? dcnt + 1 : 0;
  end

  assign bus32.imem_ack   = bus32.imem_req;
  assign bus32.imem_rdata = prog32[bus32.imem_addr[5:0]];
  assign bus32.dmem_ack   = bus32.dmem_req;
  assign bus32.dmem_rdata = (bus32.dmem_addr == 15'd0) ? 32'h8000_0000 : 32'h0000_8000;

  typedef struct { logic [14:0] pc; logic [15:0] a; logic [15:0] d; int lat; } ret_t;
  typedef struct { logic [14:0] addr; logic [15:0] data; } wr_t;
  typedef struct { logic [14:0] pc; logic [31:0] d; } r32_t;

  ret_t        ret_q[$];
  wr_t         wr_q[$];
  logic [14:0] rd_q[$];
  r32_t        q32[$];

  int n_cmp = 0;
  int n_fail = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  // 16-bit monitor: retires, latency, memory accesses and handshake stability
  int   cyc = 0;
  int   fetch_cyc = 0;
  int   dreq_seen = 0;
  int   ireq_seen = 0;
  logic pend = 1'b0;
  ret_t cur;
  logic p_req = 1'b0, p_ack = 1'b0, p_we = 1'b0;
  logic [14:0] p_addr = '0;
  logic [15:0] p_wdata = '0;

  initial begin
    wr_t  w;
    logic [14:0] ra;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        pend  = 1'b0;
        p_req = 1'b0;
      end else begin
        if (pend) begin
          chk("ret_pc", 32'(pc16), 32'(cur.pc));
          chk("ret_a",  32'(a16),  32'(cur.a));
          chk("ret_d",  32'(d16),  32'(cur.d));
          pend = 1'b0;
        end
        if (bus16.imem_req && bus16.imem_ack) fetch_cyc = cyc;
        if (ret16 && ret_q.size() > 0) begin
          cur = ret_q.pop_front();
          chk("ret_latency", 32'(cyc - fetch_cyc + 1), 32'(cur.lat));
          pend = 1'b1;
        end
        if (bus16.dmem_req) dreq_seen++;
        if (bus16.imem_req) ireq_seen++;
        if (bus16.dmem_req && p_req && !p_ack) begin
          chk("hold_addr",  32'(bus16.dmem_addr),  32'(p_addr));
          chk("hold_we",    32'(bus16.dmem_we),    32'(p_we));
          chk("hold_wdata", 32'(bus16.dmem_wdata), 32'(p_wdata));
        end
        if (bus16.dmem_req && bus16.dmem_ack) begin
          if (bus16.dmem_we) begin
            ram[bus16.dmem_addr[5:0]] = bus16.dmem_wdata;
            if (wr_q.size() > 0) begin
              w = wr_q.pop_front();
              chk("wr_addr", 32'(bus16.dmem_addr),  32'(w.addr));
              chk("wr_data", 32'(bus16.dmem_wdata), 32'(w.data));
            end
          end else if (rd_q.size() > 0) begin
            ra = rd_q.pop_front();
            chk("rd_addr", 32'(bus16.dmem_addr), 32'(ra));
          end
        end
        p_req   = bus16.dmem_req;
        p_ack   = bus16.dmem_ack;
        p_we    = bus16.dmem_we;
        p_addr  = bus16.dmem_addr;
        p_wdata = bus16.dmem_wdata;
      end
    end
  end

  // 32-bit monitor: pc and D after each retire
  logic pend32 = 1'b0;
  r32_t cur32;
  initial begin
    forever begin
      @(negedge clk);
      if (rst32) begin
        pend32 = 1'b0;
      end else begin
        if (pend32) begin
          chk("w32_pc", 32'(pc32), 32'(cur32.pc));
          chk("w32_d",  d32,       cur32.d);
          pend32 = 1'b0;
        end
        if (ret32 && q32.size() > 0) begin
          cur32  = q32.pop_front();
          pend32 = 1'b1;
        end
      end
    end
  end

  task automatic push_ret(input int p, input int a, input int d, input int lat);
    ret_t e;
    e.pc = 15'(p); e.a = 16'(a); e.d = 16'(d); e.lat = lat;
    ret_q.push_back(e);
  endtask

  task automatic push_wr(input int addr, input int data);
    wr_t w;
    w.addr = 15'(addr); w.data = 16'(data);
    wr_q.push_back(w);
  endtask

  // hold reset over two edges, check reset state, then clear memories
  task automatic begin_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_pc",       32'(pc16),              32'h0);
    chk("rst_a",        32'(a16),               32'h0);
    chk("rst_d",        32'(d16),               32'h0);
    chk("rst_imem_req", 32'(bus16.imem_req),    32'h0);
    chk("rst_dmem_req", 32'(bus16.dmem_req),    32'h0);
    chk("rst_we",       32'(bus16.dmem_we),     32'h0);
    chk("rst_wdata",    32'(bus16.dmem_wdata),  32'h0);
    chk("rst_retire",   32'(ret16),             32'h0);
    chk("rst_halted",   32'(halt16),            32'h0);
    for (int i = 0; i < 64; i++) begin
      rom[i] = 16'h0000;
      ram[i] = 16'h0000;
    end
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((ret_q.size() > 0 || pend || wr_q.size() > 0 || rd_q.size() > 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      n_cmp++;
      n_fail++;
      $display("FAIL %s: timeout with %0d retires, %0d writes, %0d reads outstanding",
               name, ret_q.size(), wr_q.size(), rd_q.size());
      ret_q.delete(); wr_q.delete(); rd_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; rst32 = 1'b1;
    iwait = 0; dwait = 0; dack_en = 1'b1; force_dack = 1'b0;
    for (int i = 0; i < 64; i++) begin
      rom[i] = 16'h0000; ram[i] = 16'h0000; prog32[i] = 16'h0000;
    end

    // WIDTH=32: D=M gives 0x8000_0000 (negative), later 0x0000_8000 (positive)
    prog32[0]  = 16'hFC10; prog32[1]  = 16'h0028; prog32[2]  = 16'hE304;
    prog32[40] = 16'hFC10; prog32[41] = 16'h0032; prog32[42] = 16'hE304;
    repeat (2) @(negedge clk);
    chk("w32_rst_pc",     32'(pc32),   32'h0);
    chk("w32_rst_halted", 32'(halt32), 32'h0);
    q32.push_back('{15'd1,  32'h8000_0000});
    q32.push_back('{15'd2,  32'h8000_0000});
    q32.push_back('{15'd40, 32'h8000_0000});
    q32.push_back('{15'd41, 32'h0000_8000});
    q32.push_back('{15'd42, 32'h0000_8000});
    q32.push_back('{15'd43, 32'h0000_8000});
    rst32 = 1'b0;
    n = 0;
    while ((q32.size() > 0 || pend32) && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) begin n_cmp++; n_fail++; $display("FAIL w32_run: timeout"); end
    rst32 = 1'b1;

    // A-instruction, zero wait: @5
    begin_reset();
    rom[0] = 16'h0005;
    push_ret(1, 5, 0, 2);
    dreq_seen = 0;
    reset = 1'b0;
    wait_done("a_inst");
    chk("a_inst_no_dmem", 32'(dreq_seen), 32'h0);

    // @5; D=A; @7; M=D+M with M[7]=3, two data wait states, one fetch wait
    begin_reset();
    rom[0] = 16'h0005; rom[1] = 16'hEC10; rom[2] = 16'h0007; rom[3] = 16'hF088;
    ram[7] = 16'd3;
    iwait = 1; dwait = 2;
    push_ret(1, 5, 0, 2); push_ret(2, 5, 5, 3); push_ret(3, 7, 5, 2); push_ret(4, 7, 5, 9);
    rd_q.push_back(15'd7);
    push_wr(7, 8);
    reset = 1'b0;
    wait_done("m_rw");
    iwait = 0; dwait = 0;

    // @10; AM=M+1 with M[10]=20: read and write at 10, then A=21
    begin_reset();
    rom[0] = 16'h000A; rom[1] = 16'hFDE8;
    ram[10] = 16'd20;
    push_ret(1, 10, 0, 2); push_ret(2, 21, 0, 5);
    rd_q.push_back(15'd10);
    push_wr(10, 21);
    reset = 1'b0;
    wait_done("am_inc");

    // D=-1; @20; D;JLT (taken) then D=0; @30; D;JGT (not taken)
    begin_reset();
    rom[0]  = 16'hEE90; rom[1]  = 16'h0014; rom[2]  = 16'hE304;
    rom[20] = 16'hEA90; rom[21] = 16'h001E; rom[22] = 16'hE301;
    push_ret(1, 0, 16'hFFFF, 3);  push_ret(2, 20, 16'hFFFF, 2);
    push_ret(20, 20, 16'hFFFF, 3); push_ret(21, 20, 0, 3);
    push_ret(22, 30, 0, 2);        push_ret(23, 30, 0, 3);
    reset = 1'b0;
    wait_done("jumps");

    // self-loop halt: @5 at pc 4, 0;JMP at pc 5
    begin_reset();
    rom[0] = 16'h0001; rom[1] = 16'h0002; rom[2] = 16'h0003; rom[3] = 16'h0004;
    rom[4] = 16'h0005; rom[5] = 16'hEA87;
    for (int i = 1; i <= 5; i++) push_ret(i, i, 0, 2);
    push_ret(5, 5, 0, 3);
    reset = 1'b0;
    wait_done("halt_run");
    chk("halted_set", 32'(halt16), 32'h1);
    ireq_seen = 0;
    repeat (10) @(negedge clk);
    chk("halt_no_fetch", 32'(ireq_seen), 32'h0);
    chk("halt_pc",       32'(pc16),      32'h5);

    // reset while a read handshake is stalled; a late ack must be ignored
    begin_reset();
    rom[0] = 16'h000A; rom[1] = 16'hFC10;
    dack_en = 1'b0;
    push_ret(1, 10, 0, 2);
    reset = 1'b0;
    wait_done("mid_pre");
    n = 0;
    while (!bus16.dmem_req && n < 50) begin @(negedge clk); n++; end
    chk("mid_req_up", 32'(bus16.dmem_req), 32'h1);
    repeat (2) @(negedge clk);
    begin_reset();
    rom[0] = 16'h0003;
    push_ret(1, 3, 0, 2);
    force_dack = 1'b1;
    reset = 1'b0;
    @(negedge clk);
    chk("late_ack_no_req", 32'(bus16.dmem_req), 32'h0);
    force_dack = 1'b0;
    dack_en = 1'b1;
    wait_done("after_mid_reset");
    chk("after_mid_dmem_idle", 32'(bus16.dmem_req), 32'h0);

    reset = 1'b1;
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
